// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered outputs and a start/busy/done handshake.
//
// Single-cycle ops (logic, add/sub, slt, shifts, mfhi/mflo) complete one cycle
// after the accepting edge. MULTU (shift-add) and DIVU (restoring) take one
// iteration per clock for WIDTH clocks, then write the HI/LO pair.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high; clears all state
//   start    operation request, sampled only while busy is low
//   op       operation code
//   dataA    operand A / dividend / multiplicand / shift source
//   dataB    operand B / divisor / multiplier
//   shamt    shift amount
//   dataOut  registered result
//   zero     registered, high when dataOut is zero
//   ovf      registered signed overflow (ADD/SUB only)
//   busy     multi-cycle operation in progress
//   done     one-cycle pulse when dataOut/zero/ovf were updated
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpSrl   = 4'b0011;
  localparam logic [3:0] OpAddu  = 4'b0100;
  localparam logic [3:0] OpSll   = 4'b0101;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpSlt   = 4'b0111;
  localparam logic [3:0] OpSra   = 4'b1000;
  localparam logic [3:0] OpMultu = 4'b1001;
  localparam logic [3:0] OpDivu  = 4'b1010;
  localparam logic [3:0] OpMfhi  = 4'b1011;
  localparam logic [3:0] OpMflo  = 4'b1100;

  // Counter must be able to hold WIDTH itself.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  // acc_q: upper product half / partial remainder.
  // mq_q:  multiplier shifting out, product lower half / quotient shifting in.
  // opb_q: multiplicand / divisor held for the whole operation.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] data_out_q;
  logic             zero_q;
  logic             ovf_q;
  logic             done_q;

  // ---------------------------------------------------------------------------
  // Single-cycle result
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [WIDTH-1:0] sc_result;
  logic             sc_ovf;

  assign add_sum  = dataA + dataB;
  assign sub_diff = dataA - dataB;

  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (op)
      OpAnd:  sc_result = dataA & dataB;
      OpOr:   sc_result = dataA | dataB;
      OpAdd: begin
        sc_result = add_sum;
        sc_ovf    = (dataA[WIDTH-1] == dataB[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != dataA[WIDTH-1]);
      end
      OpSub: begin
        sc_result = sub_diff;
        sc_ovf    = (dataA[WIDTH-1] != dataB[WIDTH-1]) &&
                    (sub_diff[WIDTH-1] != dataA[WIDTH-1]);
      end
      OpSlt:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      OpSrl:  sc_result = dataA >> shamt;
      OpSll:  sc_result = dataA << shamt;
      OpSra:  sc_result = $unsigned($signed(dataA) >>> shamt);
      OpAddu: sc_result = add_sum;
      OpMfhi: sc_result = hi_q;
      OpMflo: sc_result = lo_q;
      default: sc_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One multiply / divide iteration
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] iter_acc;
  logic [WIDTH-1:0] iter_mq;

  // Shift-add: add the multiplicand if the current multiplier bit is set,
  // then shift {carry, acc, mq} right by one.
  assign mul_addend = mq_q[0] ? opb_q : {WIDTH{1'b0}};
  assign mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};

  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The difference always fits WIDTH bits
  // because the prior remainder is below the divisor. A zero divisor always
  // "fits", which yields an all-ones quotient and the dividend as remainder.
  assign div_shift = {acc_q, mq_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_rem   = div_shift[WIDTH-1:0] - opb_q;

  always_comb begin
    iter_acc = acc_q;
    iter_mq  = mq_q;
    if (state_q == StMul) begin
      iter_acc = mul_sum[WIDTH:1];
      iter_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end else if (state_q == StDiv) begin
      iter_acc = div_ge ? div_rem : div_shift[WIDTH-1:0];
      iter_mq  = {mq_q[WIDTH-2:0], div_ge};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      mq_q       <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      data_out_q <= '0;
      zero_q     <= 1'b1;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (op == OpMultu) begin
              state_q <= StMul;
              cnt_q   <= CntInit;
              acc_q   <= '0;
              mq_q    <= dataB;
              opb_q   <= dataA;
            end else if (op == OpDivu) begin
              state_q <= StDiv;
              cnt_q   <= CntInit;
              acc_q   <= '0;
              mq_q    <= dataA;
              opb_q   <= dataB;
            end else begin
              data_out_q <= sc_result;
              zero_q     <= (sc_result == '0);
              ovf_q      <= sc_ovf;
              done_q     <= 1'b1;
            end
          end
        end
        StMul, StDiv: begin
          acc_q <= iter_acc;
          mq_q  <= iter_mq;
          cnt_q <= cnt_q - CntLast;
          if (cnt_q == CntLast) begin
            state_q    <= StIdle;
            hi_q       <= iter_acc;
            lo_q       <= iter_mq;
            data_out_q <= iter_mq;
            zero_q     <= (iter_mq == '0);
            ovf_q      <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dataOut = data_out_q;
  assign zero    = zero_q;
  assign ovf     = ovf_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle);

endmodule
